fp_mul_param: RTL and testbench



---
 rtl/fp_mul_pkg.sv | 66 ++++++
 rtl/fp_mul_classify.sv | 62 ++++++
 rtl/fp_mul_param.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_fp_mul_param.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the parametrised IEEE-754 multiplier: FSM states,
// operand classes, rounding-mode codes, flag bit positions and small pure functions.
package fp_mul_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SPECIAL,
    ST_NORM_IN,
    ST_MULT,
    ST_NORM_OUT,
    ST_ROUND,
    ST_PACK,
    ST_OUTPUT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fclass_t;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  // Canonical quiet NaN in the low 1+exp_w+man_w bits of a 64-bit word.
  function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i >= man_w && i < man_w + exp_w) begin
        v[i] = 1'b1;
      end
    end
    v[man_w-1] = 1'b1;
    return v;
  endfunction

  // Round-increment decision; codes 101-111 fall through to nearest-even.
  function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                    input logic lsb, input logic guard,
                                    input logic sticky);
    logic up;
    case (rm)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = sign & (guard | sticky);
      RM_RUP:  up = ~sign & (guard | sticky);
      RM_RMM:  up = guard;
      default: up = guard & (sticky | lsb);
    endcase
    return up;
  endfunction

endpackage

// File: rtl/fp_mul_classify.sv
// Combinational operand splitter: sign, unbiased exponent, mantissa with hidden bit
// and class. With FP_MUL_FTZ_EN defined, subnormals are reported as zero.
module fp_classify
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W,
  localparam int EW2 = EXP_W + 2
) (
  input  logic [W-1:0]           i_op,
  output logic                   o_sign,
  output logic signed [EW2-1:0]  o_exp,
  output logic [MAN_W:0]         o_mant,
  output fclass_t                o_class
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW2-1:0] BIAS_S = EW2'(BIAS);
  localparam logic signed [EW2-1:0] EMIN_S = EW2'(1 - BIAS);

  logic [EXP_W-1:0] w_exp_f;
  logic [MAN_W-1:0] w_frac;

  assign w_exp_f = i_op[W-2:MAN_W];
  assign w_frac  = i_op[MAN_W-1:0];

  // Field decode and classification.
  always_comb begin
    o_sign  = i_op[W-1];
    o_exp   = '0;
    o_mant  = '0;
    o_class = CLS_ZERO;
    if (&w_exp_f) begin
      o_mant = {1'b1, w_frac};
      if (w_frac == '0) begin
        o_class = CLS_INF;
      end else if (w_frac[MAN_W-1]) begin
        o_class = CLS_QNAN;
      end else begin
        o_class = CLS_SNAN;
      end
    end else if (w_exp_f == '0) begin
      o_exp = EMIN_S;
      if (w_frac == '0) begin
        o_class = CLS_ZERO;
      end else begin
`ifdef FP_MUL_FTZ_EN
        o_class = CLS_ZERO;
`else
        o_class = CLS_SUB;
        o_mant  = {1'b0, w_frac};
`endif
      end
    end else begin
      o_class = CLS_NORM;
      o_mant  = {1'b1, w_frac};
      o_exp   = $signed({2'b00, w_exp_f}) - BIAS_S;
    end
  end

endmodule

// File: rtl/fp_mul_param.sv
// Multi-cycle IEEE-754 multiplier with EXP_W/MAN_W format, five rounding modes and
// RISC-V flags. Define FP_MUL_FTZ_EN to flush subnormal inputs and results to zero.
module fp_mul_param
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_rm,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z,
  output logic [4:0]   out_flags
);

  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int SHW  = $clog2(PW + 1);
  localparam int CNTW = $clog2(MAN_W + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [EW2-1:0] ONE_S  = {{(EW2-1){1'b0}}, 1'b1};
  localparam logic signed [EW2-1:0] EMIN_S = EW2'(1 - BIAS);
  localparam logic signed [EW2-1:0] EMAX_S = EW2'(BIAS);
  localparam logic signed [EW2-1:0] PW_S   = EW2'(PW);
  localparam logic [EXP_W-1:0]      BIAS_E = EXP_W'(BIAS);
  localparam logic [CNTW-1:0]       CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0]       CNT_MAX = CNTW'(MAN_W);
  localparam logic [63:0]           NAN64  = canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]          QNAN   = NAN64[W-1:0];
  localparam logic [W-2:0]          MAXF   = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
  localparam logic [W-2:0]          INFF   = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  state_t                r_state;
  logic [W-1:0]          r_a, r_b;
  logic [2:0]            r_rm;
  logic                  r_sa, r_sb, r_sz;
  logic signed [EW2-1:0] r_ea, r_eb, r_ez, r_e;
  logic [MAN_W:0]        r_ma, r_mb, r_mant;
  fclass_t               r_ca, r_cb;
  logic [CNTW-1:0]       r_cnt;
  logic [PW-1:0]         r_prod;
  logic                  r_g, r_r, r_s, r_tiny, r_nx;
  logic [W-1:0]          r_res, r_out_z;
  logic [4:0]            r_res_flags, r_out_flags;
  logic                  r_out_valid;

  logic                  w_sa, w_sb;
  logic signed [EW2-1:0] w_ea, w_eb;
  logic [MAN_W:0]        w_ma, w_mb;
  fclass_t               w_ca, w_cb;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .i_op(r_a), .o_sign(w_sa), .o_exp(w_ea), .o_mant(w_ma), .o_class(w_ca)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .i_op(r_b), .o_sign(w_sb), .o_exp(w_eb), .o_mant(w_mb), .o_class(w_cb)
  );

  logic         w_a_nan, w_b_nan, w_any_snan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic         w_spec_hit, w_spec_sz;
  logic [W-1:0] w_spec_z;
  logic [4:0]   w_spec_flags;

  assign w_a_nan    = (r_ca == CLS_QNAN) || (r_ca == CLS_SNAN);
  assign w_b_nan    = (r_cb == CLS_QNAN) || (r_cb == CLS_SNAN);
  assign w_any_snan = (r_ca == CLS_SNAN) || (r_cb == CLS_SNAN);
  assign w_a_inf    = (r_ca == CLS_INF);
  assign w_b_inf    = (r_cb == CLS_INF);
  assign w_a_zero   = (r_ca == CLS_ZERO);
  assign w_b_zero   = (r_cb == CLS_ZERO);
  assign w_spec_sz  = r_sa ^ r_sb;

  // Special-operand resolution; NaN and inf*0 take precedence over inf and zero.
  always_comb begin
    w_spec_hit   = 1'b1;
    w_spec_z     = '0;
    w_spec_flags = 5'b00000;
    if (w_a_nan || w_b_nan) begin
      w_spec_z             = QNAN;
      w_spec_flags[FLG_NV] = w_any_snan;
    end else if ((w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
      w_spec_z             = QNAN;
      w_spec_flags[FLG_NV] = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_z = {w_spec_sz, INFF};
    end else if (w_a_zero || w_b_zero) begin
      w_spec_z = {w_spec_sz, {(W-1){1'b0}}};
    end else begin
      w_spec_hit = 1'b0;
    end
  end

  logic [PW-1:0] w_prod;
  assign w_prod = {{(MAN_W+1){1'b0}}, r_ma} * {{(MAN_W+1){1'b0}}, r_mb};

  // Output normalisation: product MSB fold-in, then denormalising barrel shift.
  logic                  w_top, w_under, w_lost, w_unb_up, w_tiny;
  logic [PW-1:0]         w_n, w_hi;
  logic signed [EW2-1:0] w_e1, w_diff, w_e2;
  logic [SHW-1:0]        w_sh_amt;
  logic [2*PW-1:0]       w_wide;

  assign w_top    = r_prod[PW-1];
  assign w_n      = w_top ? r_prod : {r_prod[PW-2:0], 1'b0};
  assign w_e1     = w_top ? (r_ez + ONE_S) : r_ez;
  assign w_under  = (w_e1 < EMIN_S);
  assign w_diff   = EMIN_S - w_e1;
  assign w_sh_amt = !w_under ? '0 : ((w_diff > PW_S) ? SHW'(PW) : w_diff[SHW-1:0]);
  assign w_wide   = {w_n, {PW{1'b0}}} >> w_sh_amt;
  assign w_hi     = w_wide[2*PW-1:PW];
  assign w_lost   = |w_wide[PW-1:0];
  assign w_e2     = w_under ? EMIN_S : w_e1;
  // A value one binade below emin that would round up to 2^emin at full precision is not tiny.
  assign w_unb_up = round_up(r_rm, r_sz, w_n[MAN_W+1], w_n[MAN_W], |w_n[MAN_W-1:0]);
  assign w_tiny   = w_under && !((w_diff == ONE_S) && (&w_n[PW-2:MAN_W+1]) && w_unb_up);

  logic                  w_inc, w_nx;
  logic [MAN_W+1:0]      w_sum;
  logic [MAN_W:0]        w_rmant;
  logic signed [EW2-1:0] w_re;

  assign w_inc   = round_up(r_rm, r_sz, r_mant[0], r_g, r_r | r_s);
  assign w_sum   = {1'b0, r_mant} + {{(MAN_W+1){1'b0}}, w_inc};
  assign w_rmant = w_sum[MAN_W+1] ? w_sum[MAN_W+1:1] : w_sum[MAN_W:0];
  assign w_re    = w_sum[MAN_W+1] ? (r_e + ONE_S) : r_e;
  assign w_nx    = r_g | r_r | r_s;

  logic             w_ovf;
  logic [EXP_W-1:0] w_bexp;
  logic [W-1:0]     w_pk_z;
  logic [4:0]       w_pk_flags;

  assign w_ovf  = r_mant[MAN_W] && (r_e > EMAX_S);
  assign w_bexp = r_e[EXP_W-1:0] + BIAS_E;

  // Rebias and resolve overflow per rounding direction.
  always_comb begin
    w_pk_z     = '0;
    w_pk_flags = 5'b00000;
    if (w_ovf) begin
      w_pk_flags[FLG_OF] = 1'b1;
      w_pk_flags[FLG_NX] = 1'b1;
      case (r_rm)
        RM_RTZ:  w_pk_z = {r_sz, MAXF};
        RM_RDN:  w_pk_z = r_sz ? {r_sz, INFF} : {r_sz, MAXF};
        RM_RUP:  w_pk_z = r_sz ? {r_sz, MAXF} : {r_sz, INFF};
        default: w_pk_z = {r_sz, INFF};
      endcase
`ifdef FP_MUL_FTZ_EN
    end else if (!r_mant[MAN_W]) begin
      w_pk_z             = {r_sz, {(W-1){1'b0}}};
      w_pk_flags[FLG_UF] = 1'b1;
      w_pk_flags[FLG_NX] = 1'b1;
`endif
    end else begin
      w_pk_z             = {r_sz, (r_mant[MAN_W] ? w_bexp : {EXP_W{1'b0}}), r_mant[MAN_W-1:0]};
      w_pk_flags[FLG_NX] = r_nx;
      w_pk_flags[FLG_UF] = r_tiny & r_nx;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_rm        <= 3'b000;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_sz        <= 1'b0;
      r_ea        <= '0;
      r_eb        <= '0;
      r_ez        <= '0;
      r_e         <= '0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_mant      <= '0;
      r_ca        <= CLS_ZERO;
      r_cb        <= CLS_ZERO;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_g         <= 1'b0;
      r_r         <= 1'b0;
      r_s         <= 1'b0;
      r_tiny      <= 1'b0;
      r_nx        <= 1'b0;
      r_res       <= '0;
      r_res_flags <= 5'b00000;
      r_out_valid <= 1'b0;
      r_out_z     <= '0;
      r_out_flags <= 5'b00000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_rm    <= in_rm;
            r_state <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          r_sa    <= w_sa;
          r_sb    <= w_sb;
          r_ea    <= w_ea;
          r_eb    <= w_eb;
          r_ma    <= w_ma;
          r_mb    <= w_mb;
          r_ca    <= w_ca;
          r_cb    <= w_cb;
          r_cnt   <= '0;
          r_state <= ST_SPECIAL;
        end
        ST_SPECIAL: begin
          if (w_spec_hit) begin
            r_res       <= w_spec_z;
            r_res_flags <= w_spec_flags;
            r_state     <= ST_OUTPUT;
          end else begin
`ifdef FP_MUL_FTZ_EN
            r_state <= ST_MULT;
`else
            r_state <= ST_NORM_IN;
`endif
          end
        end
        ST_NORM_IN: begin
          if ((r_ma[MAN_W] && r_mb[MAN_W]) || (r_cnt == CNT_MAX)) begin
            r_state <= ST_MULT;
          end else begin
            if (!r_ma[MAN_W]) begin
              r_ma <= {r_ma[MAN_W-1:0], 1'b0};
              r_ea <= r_ea - ONE_S;
            end
            if (!r_mb[MAN_W]) begin
              r_mb <= {r_mb[MAN_W-1:0], 1'b0};
              r_eb <= r_eb - ONE_S;
            end
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_MULT: begin
          r_prod  <= w_prod;
          r_ez    <= r_ea + r_eb;
          r_sz    <= r_sa ^ r_sb;
          r_state <= ST_NORM_OUT;
        end
        ST_NORM_OUT: begin
          r_mant  <= w_hi[PW-1:MAN_W+1];
          r_g     <= w_hi[MAN_W];
          r_r     <= w_hi[MAN_W-1];
          r_s     <= (|w_hi[MAN_W-2:0]) | w_lost;
          r_e     <= w_e2;
          r_tiny  <= w_tiny;
          r_state <= ST_ROUND;
        end
        ST_ROUND: begin
          r_mant  <= w_rmant;
          r_e     <= w_re;
          r_nx    <= w_nx;
          r_state <= ST_PACK;
        end
        ST_PACK: begin
          r_res       <= w_pk_z;
          r_res_flags <= w_pk_flags;
          r_state     <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_z     <= r_res;
            r_out_flags <= r_res_flags;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign out_z     = r_out_z;
  assign out_flags = r_out_flags;

endmodule

// File: tb/tb_fp_mul_param.sv
// Directed bench for fp_mul_param: binary32 instance plus a binary16 instance.
module tb_fp_mul_param;

  logic        clk;
  logic        reset_n;
  logic        v32, rdy32, ov32, ordy32;
  logic [31:0] a32, b32, z32;
  logic [2:0]  rm32;
  logic [4:0]  f32;
  logic        v16, rdy16, ov16, ordy16;
  logic [15:0] a16, b16, z16;
  logic [2:0]  rm16;
  logic [4:0]  f16;

  int total;
  int bad;

  fp_mul_param #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(v32), .in_ready(rdy32),
    .in_a(a32), .in_b(b32), .in_rm(rm32), .out_valid(ov32),
    .out_ready(ordy32), .out_z(z32), .out_flags(f32)
  );

  fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(v16), .in_ready(rdy16),
    .in_a(a16), .in_b(b16), .in_rm(rm16), .out_valid(ov16),
    .out_ready(ordy16), .out_z(z16), .out_flags(f16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on the selected instance, checking latency and result.
  task automatic op(input bit h, input logic [31:0] a, input logic [31:0] b,
                    input logic [2:0] rm, input logic [31:0] ez, input logic [4:0] ef,
                    input int lat, input string tag);
    int n;
    @(negedge clk);
    chk({tag, " in_ready"}, h ? rdy16 : rdy32, 64'd1);
    if (h) begin
      v16 = 1'b1; a16 = a[15:0]; b16 = b[15:0]; rm16 = rm;
    end else begin
      v32 = 1'b1; a32 = a; b32 = b; rm32 = rm;
    end
    @(posedge clk);
    #1;
    v16 = 1'b0;
    v32 = 1'b0;
    n = 0;
    while (((h ? ov16 : ov32) !== 1'b1) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " z"}, h ? {48'h0, z16} : {32'h0, z32}, {32'h0, ez});
    chk({tag, " flags"}, h ? {59'h0, f16} : {59'h0, f32}, {59'h0, ef});
    if (h) ordy16 = 1'b1;
    else ordy32 = 1'b1;
    @(posedge clk);
    #1;
    ordy16 = 1'b0;
    ordy32 = 1'b0;
    chk({tag, " valid drop"}, h ? ov16 : ov32, 64'd0);
    chk({tag, " ready back"}, h ? rdy16 : rdy32, 64'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    v32 = 1'b0; a32 = 32'h0; b32 = 32'h0; rm32 = 3'd0; ordy32 = 1'b0;
    v16 = 1'b0; a16 = 16'h0; b16 = 16'h0; rm16 = 3'd0; ordy16 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", ov32, 64'd0);
    chk("reset out_z", z32, 64'd0);
    chk("reset out_flags", f32, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset in_ready", rdy32, 64'd1);

    op(1'b0, 32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'h00, 8, "1.5x2");
    op(1'b0, 32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'h10, 3, "inf*0");
    op(1'b0, 32'h7FA00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h10, 3, "snan");
    op(1'b0, 32'h7FC00000, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h00, 3, "qnan");
    op(1'b0, 32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'h00, 3, "-inf*2");
    op(1'b0, 32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 5'h00, 3, "-0*2");
    op(1'b0, 32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'h05, 8, "ovf rne");
    op(1'b0, 32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'h05, 8, "ovf rtz");
    op(1'b0, 32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'h05, 8, "ovf rup neg");
    op(1'b0, 32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 5'h05, 8, "ovf rdn neg");
    op(1'b0, 32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 5'h01, 8, "nx rne");
    op(1'b0, 32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 5'h01, 8, "nx rup");
    op(1'b0, 32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800002, 5'h01, 8, "nx rdn");
`ifdef FP_MUL_FTZ_EN
    op(1'b0, 32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 5'h03, 7, "sub out");
    op(1'b0, 32'h00800001, 32'h3F000000, 3'd0, 32'h00000000, 5'h03, 7, "sub out nx");
    op(1'b0, 32'h00000001, 32'h7E800000, 3'd0, 32'h00000000, 5'h00, 3, "sub in");
`else
    op(1'b0, 32'h00800000, 32'h3F000000, 3'd0, 32'h00400000, 5'h00, 8, "sub out");
    op(1'b0, 32'h00800001, 32'h3F000000, 3'd0, 32'h00400000, 5'h03, 8, "sub out nx");
    op(1'b0, 32'h00000001, 32'h7E800000, 3'd0, 32'h34000000, 5'h00, 31, "sub in");
`endif

    // Back-pressure: result held stable for five cycles.
    @(negedge clk);
    v32 = 1'b1; a32 = 32'h3FC00000; b32 = 32'h40000000; rm32 = 3'd0;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("stall valid", ov32, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall hold valid", ov32, 64'd1);
      chk("stall hold z", z32, 64'h40400000);
      chk("stall hold flags", f32, 64'd0);
      chk("stall in_ready", rdy32, 64'd0);
    end
    ordy32 = 1'b1;
    @(posedge clk);
    #1;
    ordy32 = 1'b0;
    chk("stall release", ov32, 64'd0);

    // Reset while the multiply stage is active.
    @(negedge clk);
    v32 = 1'b1; a32 = 32'h3F800001; b32 = 32'h3F800001; rm32 = 3'd0;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("abort in_ready", rdy32, 64'd1);
    chk("abort flags", f32, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("abort no valid", ov32, 64'd0);
    end

    op(1'b1, 32'h00003E00, 32'h00004000, 3'd0, 32'h00004200, 5'h00, 8, "h 1.5x2");
    op(1'b1, 32'h00007C00, 32'h00000000, 3'd0, 32'h00007E00, 5'h10, 3, "h inf*0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
